// File: rtl/pe_layer_ctrl.sv
// Single-layer NTT/INTT butterfly sequencer wrapped around a fixed-latency PE3 butterfly.
// Optional cycle counter on cyc_cnt is built only when PE_LAYER_PERF_EN is defined.
module pe_layer_ctrl #(
  parameter int DW     = 12,
  parameter int AW     = 8,
  parameter int PE_LAT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [2:0]    len_log,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [DW-1:0] rd_data_a,
  input  logic [DW-1:0] rd_data_b,
  output logic          pe_sel,
  output logic [DW-1:0] pe_u,
  output logic [DW-1:0] pe_v,
  input  logic [DW-1:0] pe_upper,
  input  logic [DW-1:0] pe_lower,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b,
  output logic [DW-1:0] wr_data_a,
  output logic [DW-1:0] wr_data_b,
  output logic [15:0]   cyc_cnt
);

  localparam int         TAG_D   = 2 + PE_LAT;
  localparam int         KW      = AW - 1;
  localparam logic [2:0] LEN_MAX = 3'(AW - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
  } tag_t;

  state_t          r_state, w_next;
  logic            w_accept;
  logic [KW-1:0]   r_k;
  logic            r_mode;
  logic [2:0]      r_len;
  tag_t            r_tag [TAG_D];
  logic [DW-1:0]   r_pe_u, r_pe_v;
  logic            w_tag_busy;
  logic [2:0]      w_len_sat;
  logic [AW-1:0]   w_k_ext, w_len_bit, w_mask, w_addr_a, w_addr_b;

  assign w_len_sat = (len_log > LEN_MAX) ? LEN_MAX : len_log;

  // Insert a zero at bit r_len of k; the partner sits exactly len above.
  assign w_k_ext   = AW'(r_k);
  assign w_len_bit = AW'(1) << r_len;
  assign w_mask    = w_len_bit - AW'(1);
  assign w_addr_a  = ((w_k_ext & ~w_mask) << 1) | (w_k_ext & w_mask);
  assign w_addr_b  = w_addr_a | w_len_bit;

  // Stages 0..TAG_D-2 empty means the final tag is leaving on this cycle.
  always_comb begin
    w_tag_busy = 1'b0;
    for (int i = 0; i < TAG_D - 1; i++) w_tag_busy = w_tag_busy | r_tag[i].valid;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start) begin
                 w_next   = S_RUN;
                 w_accept = 1'b1;
               end
      S_RUN:   if (r_k == '1) w_next = S_DRAIN;
      S_DRAIN: if (!w_tag_busy) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_mode  <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_k    <= '0;
        r_mode <= mode;
        r_len  <= w_len_sat;
      end else if (r_state == S_RUN) begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign rd_en     = (r_state == S_RUN);
  assign rd_addr_a = rd_en ? w_addr_a : '0;
  assign rd_addr_b = rd_en ? w_addr_b : '0;

  // NOTE: the tag line is reset because its valid bits drive wr_en; an abort must not write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAG_D; i++) r_tag[i] <= '0;
      r_pe_u <= '0;
      r_pe_v <= '0;
    end else begin
      r_tag[0] <= '{valid: rd_en, addr_a: rd_addr_a, addr_b: rd_addr_b};
      for (int i = 1; i < TAG_D; i++) r_tag[i] <= r_tag[i-1];
      r_pe_u <= rd_data_a;
      r_pe_v <= rd_data_b;
    end
  end

  assign pe_sel    = r_mode;
  assign pe_u      = r_pe_u;
  assign pe_v      = r_pe_v;
  assign wr_en     = r_tag[TAG_D-1].valid;
  assign wr_addr_a = r_tag[TAG_D-1].addr_a;
  assign wr_addr_b = r_tag[TAG_D-1].addr_b;
  assign wr_data_a = pe_upper;
  assign wr_data_b = pe_lower;

`ifdef PE_LAYER_PERF_EN
  logic [15:0] r_cyc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_cyc <= '0;
    else if (w_accept) r_cyc <= '0;
    else if (busy)     r_cyc <= r_cyc + 16'd1;
  end

  assign cyc_cnt = r_cyc;
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_layer_ctrl.sv
// Bench for pe_layer_ctrl: behavioural RAM and PE3 stand-in, event logs, and a
// per-layer reference computed from the address/timing rules.
module tb_pe_layer_ctrl;

  localparam int DW = 12, AW = 8, PE_LAT = 8, N = 256, NBF = 128;
`ifdef PE_LAYER_PERF_EN
  localparam int EXP_CYC = 138;
`else
  localparam int EXP_CYC = 0;
`endif

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
  logic [2:0]    len_log = '0;
  logic          busy, done, rd_en, pe_sel, wr_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [DW-1:0] rd_data_a = '0, rd_data_b = '0;
  logic [DW-1:0] pe_u, pe_v, pe_upper, pe_lower, wr_data_a, wr_data_b;
  logic [15:0]   cyc_cnt;

  always #5 clk = ~clk;

  pe_layer_ctrl #(.DW(DW), .AW(AW), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len_log(len_log),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .pe_sel(pe_sel), .pe_u(pe_u), .pe_v(pe_v),
    .pe_upper(pe_upper), .pe_lower(pe_lower), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b), .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .cyc_cnt(cyc_cnt)
  );

  // Coefficient RAM: synchronous read, in-place write, bulk preload from img.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] img [N];
  logic          load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) mem[i] <= img[i];
    end else if (wr_en) begin
      mem[wr_addr_a] <= wr_data_a;
      mem[wr_addr_b] <= wr_data_b;
    end
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
  end

  // PE3 stand-in: arbitrary sel-dependent butterfly with PE_LAT cycles of latency.
  function automatic logic [2*DW-1:0] bfly(input logic [DW-1:0] u, input logic [DW-1:0] v,
                                           input logic sel);
    logic [DW-1:0] hi, lo;
    if (!sel) begin
      hi = u + v;
      lo = u - v;
    end else begin
      hi = u + v + DW'(1);
      lo = v - u;
    end
    return {hi, lo};
  endfunction

  logic [2*DW-1:0] pe_pipe [PE_LAT];
  always @(posedge clk) begin
    pe_pipe[0] <= bfly(pe_u, pe_v, pe_sel);
    for (int i = 1; i < PE_LAT; i++) pe_pipe[i] <= pe_pipe[i-1];
  end
  assign pe_upper = pe_pipe[PE_LAT-1][2*DW-1:DW];
  assign pe_lower = pe_pipe[PE_LAT-1][DW-1:0];

  // Event logs; times are the rising edge at which the event is sampled.
  typedef struct { int t; int a; int b; } ev_t;
  ev_t  rd_q[$], wr_q[$];
  int   done_q[$], busy_q[$];
  int   edge_n = 0, sel_bad = 0, cyc_nz = 0;
  logic exp_sel = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (rd_en) rd_q.push_back('{t: edge_n + 1, a: int'(rd_addr_a), b: int'(rd_addr_b)});
    if (wr_en) wr_q.push_back('{t: edge_n + 1, a: int'(wr_addr_a), b: int'(wr_addr_b)});
    if (done) done_q.push_back(edge_n + 1);
    if (busy) busy_q.push_back(edge_n + 1);
    if ((busy || done) && pe_sel !== exp_sel) sel_bad = sel_bad + 1;
    if (cyc_cnt !== 16'(EXP_CYC) && EXP_CYC == 0) cyc_nz = cyc_nz + 1;
  end

  int n_checks = 0, n_fail = 0;

  function automatic int ref_a(input int k, input int l);
    int len = 1 << l;
    return (k / len) * 2 * len + (k % len);
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, rd_en, wr_en, pe_sel} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl busy/done/rd_en/wr_en/pe_sel=%b required 00000",
               {busy, done, rd_en, wr_en, pe_sel});
    end
    n_checks++;
    if ({rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr rd=(%0d,%0d) wr=(%0d,%0d) required zeros",
               rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b);
    end
    n_checks++;
    if ({pe_u, pe_v, cyc_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_data pe_u=%0d pe_v=%0d cyc_cnt=%0d required 0", pe_u, pe_v, cyc_cnt);
    end
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, rd_en, wr_en} !== 3'b0) begin
        n_fail++;
        $display("FAIL idle_quiet cycle %0d busy/rd_en/wr_en=%b required 000", c, {busy, rd_en, wr_en});
      end
    end
  endtask

  // Runs one layer with random RAM contents and checks schedule, addresses, data and counters.
  task automatic test_layer(input logic [2:0] l_req, input logic m, input bit inj, output int rb);
    int lsat, len, t0, wb, db, bb, sb, nr, nw, ea;
    bit got_done;
    logic [DW-1:0] exp_mem [N];
    logic [2*DW-1:0] r;
    lsat = (int'(l_req) > AW - 1) ? AW - 1 : int'(l_req);
    len  = 1 << lsat;
    for (int i = 0; i < N; i++) img[i] = DW'($urandom);
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
    for (int i = 0; i < N; i++) exp_mem[i] = img[i];
    for (int k = 0; k < NBF; k++) begin
      ea = ref_a(k, lsat);
      r  = bfly(img[ea], img[ea+len], m);
      exp_mem[ea]     = r[2*DW-1:DW];
      exp_mem[ea+len] = r[DW-1:0];
    end
    rb = rd_q.size(); wb = wr_q.size(); db = done_q.size(); bb = busy_q.size(); sb = sel_bad;
    @(negedge clk);
    exp_sel = m; mode = m; len_log = l_req; start = 1'b1; t0 = edge_n + 1;
    @(negedge clk);
    start = 1'b0; mode = ~m; len_log = 3'($urandom);
    got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      @(negedge clk);
      start = inj && (edge_n == t0 + 49);
      if (done) begin
        got_done = 1'b1;
        start = inj;
      end
    end
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL done_timeout layer l=%0d m=%0d no done within 400 cycles", l_req, m);
    end
    nr = rd_q.size() - rb;
    nw = wr_q.size() - wb;
    n_checks++;
    if (nr != NBF || nw != NBF) begin
      n_fail++;
      $display("FAIL rw_count reads=%0d writes=%0d required %0d each", nr, nw, NBF);
    end
    for (int i = 0; i < NBF && i < nr; i++) begin
      ev_t e = rd_q[rb+i];
      ea = ref_a(i, lsat);
      n_checks++;
      if (e.t != t0 + 1 + i || e.a != ea || e.b != ea + len) begin
        n_fail++;
        $display("FAIL read[%0d] got t=%0d (%0d,%0d) required t=%0d (%0d,%0d)",
                 i, e.t - t0, e.a, e.b, 1 + i, ea, ea + len);
      end
    end
    for (int i = 0; i < NBF && i < nw; i++) begin
      ev_t e = wr_q[wb+i];
      ea = ref_a(i, lsat);
      n_checks++;
      if (e.t != t0 + 3 + PE_LAT + i || e.a != ea || e.b != ea + len) begin
        n_fail++;
        $display("FAIL write[%0d] got t=%0d (%0d,%0d) required t=%0d (%0d,%0d)",
                 i, e.t - t0, e.a, e.b, 3 + PE_LAT + i, ea, ea + len);
      end
    end
    n_checks++;
    if (done_q.size() != db + 1 || (done_q.size() > db && done_q[db] != t0 + NBF + PE_LAT + 3)) begin
      n_fail++;
      $display("FAIL done_pulse count=%0d first_t=%0d required 1 at t=%0d", done_q.size() - db,
               (done_q.size() > db) ? done_q[db] - t0 : -1, NBF + PE_LAT + 3);
    end
    n_checks++;
    if (busy_q.size() - bb != NBF + PE_LAT + 2 ||
        (busy_q.size() > bb && (busy_q[bb] != t0 + 1 || busy_q[busy_q.size()-1] != t0 + NBF + PE_LAT + 2))) begin
      n_fail++;
      $display("FAIL busy_window cycles=%0d required %0d from t=1", busy_q.size() - bb, NBF + PE_LAT + 2);
    end
    n_checks++;
    if (sel_bad != sb || pe_sel !== m) begin
      n_fail++;
      $display("FAIL pe_sel bad_cycles=%0d idle_value=%b required 0 and %b", sel_bad - sb, pe_sel, m);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL ram[%0d] got %0d required %0d (l=%0d m=%0d)", i, mem[i], exp_mem[i], lsat, m);
      end
    end
    n_checks++;
    if (cyc_cnt !== 16'(EXP_CYC)) begin
      n_fail++;
      $display("FAIL cyc_cnt got %0d required %0d", cyc_cnt, EXP_CYC);
    end
  endtask

  task automatic test_addr_map();
    int rb;
    test_layer(3'd0, 1'($urandom), 1'b0, rb);
    test_layer(3'd3, 1'($urandom), 1'b0, rb);
    n_checks++;
    if (rd_q.size() < rb + 16 || rd_q[rb+8].a != 16 || rd_q[rb+8].b != 24 ||
        rd_q[rb+15].a != 23 || rd_q[rb+15].b != 31) begin
      n_fail++;
      $display("FAIL addr_map_l3 k8=(%0d,%0d) k15=(%0d,%0d) required (16,24) (23,31)",
               (rd_q.size() > rb + 8) ? rd_q[rb+8].a : -1, (rd_q.size() > rb + 8) ? rd_q[rb+8].b : -1,
               (rd_q.size() > rb + 15) ? rd_q[rb+15].a : -1, (rd_q.size() > rb + 15) ? rd_q[rb+15].b : -1);
    end
  endtask

  task automatic test_abort();
    int l, t0, wb, db, rb;
    bit hit;
    l = int'($urandom_range(0, AW - 1));
    db = done_q.size();
    @(negedge clk);
    exp_sel = 1'b1; mode = 1'b1; len_log = 3'(l); start = 1'b1; t0 = edge_n + 1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      hit = (edge_n == t0 + 50);
    end
    n_checks++;
    if (!hit || rd_addr_a !== AW'(ref_a(50, l)) || wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup rd_addr_a=%0d wr_en=%b required %0d and 1", rd_addr_a, wr_en, ref_a(50, l));
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, rd_en, busy} !== 3'b0) begin
      n_fail++;
      $display("FAIL abort_async wr_en/rd_en/busy=%b required 000", {wr_en, rd_en, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wb = wr_q.size();
    repeat (30) @(negedge clk);
    n_checks++;
    if (wr_q.size() != wb || done_q.size() != db) begin
      n_fail++;
      $display("FAIL abort_quiet writes=%0d dones=%0d required 0 and 0", wr_q.size() - wb, done_q.size() - db);
    end
    test_layer(3'(l), 1'($urandom), 1'b0, rb);
  endtask

  initial begin
    int rb;
    test_reset();
    test_layer(3'd7, 1'b0, 1'b0, rb);                    // NTT, widest span
    test_addr_map();
    test_layer(3'd7, 1'b1, 1'b0, rb);                    // INTT data path
    test_layer(3'($urandom), 1'($urandom), 1'b1, rb);    // stray starts ignored
    test_abort();
    for (int i = 0; i < 3; i++) test_layer(3'($urandom), 1'($urandom), 1'b0, rb);
    n_checks++;
    if (cyc_nz != 0) begin
      n_fail++;
      $display("FAIL cyc_cnt_tied nonzero_cycles=%0d required 0", cyc_nz);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_layer_ctrl.md
# pe_layer_ctrl

Single-layer butterfly sequencer that sits directly upstream of the PE3 butterfly and wraps around it. On `start` it walks every butterfly of one NTT/INTT layer over an N-point coefficient RAM. For each butterfly it issues paired reads, registers the operands onto PE3's `u`/`v`, and drives `sel`. It carries address tags through a delay line matched to PE3's fixed latency, so `bf_upper`/`bf_lower` are written back in place to the correct addresses. PE3 has no valid/stall, so the pipeline is free-running and strictly fixed-latency.

## Interface
- `DW`, 12, coefficient width (matches PE3 `data_width`)
- `AW`, 8, RAM address width; N = 2^AW, butterflies per layer = 2^(AW-1)
- `PE_LAT`, 8, PE3 input-to-output latency in cycles
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `start`  in  1  layer request; sampled only in IDLE
- `mode`  in  1  0 = NTT, 1 = INTT; latched at accepted start
- `len_log`  in  3  log2 of butterfly span; latched at accepted start
- `busy`  out  1  high while a layer is in flight
- `done`  out  1  one-cycle pulse at layer completion
- `rd_en`  out  1  RAM read strobe
- `rd_addr_a`, `rd_addr_b`  out  AW  read addresses
- `rd_data_a`, `rd_data_b`  in  DW  read data, valid 1 cycle after `rd_en`
- `pe_sel`  out  1  to PE3 `sel`
- `pe_u`, `pe_v`  out  DW  to PE3 `u`, `v` (registered)
- `pe_upper`, `pe_lower`  in  DW  from PE3 `bf_upper`, `bf_lower`
- `wr_en`  out  1  RAM write strobe
- `wr_addr_a`, `wr_addr_b`  out  AW  write addresses
- `wr_data_a`, `wr_data_b`  out  DW  = `pe_upper`, `pe_lower` (combinational pass)
- `cyc_cnt`  out  16  layer cycle count (see Configuration)

## Operation
- FSM states and transitions:
  - IDLE→RUN on `start`=1.
  - RUN→DRAIN after butterfly index k = 2^(AW-1)−1 is issued.
  - DRAIN→DONE when the tag pipeline is empty.
  - DONE→IDLE unconditionally (one cycle).
- `start` outside IDLE is ignored. `mode`/`len_log` changes after acceptance are ignored.
- `len_log` values above AW−1 saturate to AW−1; len = 2^len_log.
- Index k is an (AW−1)-bit counter, reset to 0 on start acceptance, incremented once per RUN cycle.
- Address mapping (insert a 0 at bit len_log):
  - `rd_addr_a` = ((k >> len_log) << (len_log+1)) | (k & (len−1))
  - `rd_addr_b` = `rd_addr_a` + len
  - No wrap-around: `rd_addr_b` ≤ N−1 always.
- `rd_en` = 1 exactly in RUN cycles (2^(AW-1) cycles, no bubbles).
- Tag pipeline:
  - Depth 2+PE_LAT; each entry holds {valid, addr_a, addr_b}.
  - Shifts every cycle in all states.
  - Stage 0 is loaded from the issue cycle.
- `pe_u`/`pe_v` register `rd_data_a`/`rd_data_b` one cycle after read data returns.
- `wr_en`, `wr_addr_a`, and `wr_addr_b` are taken from the last tag stage.
- `pe_sel` = latched mode. It is held from start acceptance through DONE and keeps its value in IDLE.

## Timing
- Reset values: all outputs 0; FSM = IDLE; tags invalid; k = 0. Async assertion clears `wr_en`/`rd_en` immediately.
- Start sampled at edge T. For N = 256:
  - RUN covers edges T+1..T+128.
  - Butterfly k is read at cycle T+1+k.
  - `pe_u`/`pe_v` are valid at T+3+k.
  - Its write (`wr_en`=1) occurs at T+3+k+PE_LAT = T+11+k.
- Last write at T+138. DONE cycle at T+139: `done`=1, `busy`=0.
- `busy`=1 for cycles T+1..T+138.
- Issue-to-write latency = 2 + PE_LAT = 10 cycles.
- Reset mid-layer aborts: no further writes, no `done` pulse; the next start restarts at k = 0.
- Back-to-back layers: `start` asserted during DONE is ignored; accepted earliest on the first IDLE cycle.

## Configuration
- `PE_LAYER_PERF_EN` defined:
  - `cyc_cnt` clears on start acceptance and increments each cycle while `busy`.
  - It holds its value after `done` until the next start.
  - Expected value for N = 256, PE_LAT = 8: 138.
- Not defined: counter not built; `cyc_cnt` tied to 0.

## Test plan
- Reset: `rst`=0 for 3 cycles → every output 0; `rst`=1 with no `start` → `busy`/`rd_en`/`wr_en` stay 0.
- NTT layer: `len_log`=7, `mode`=0, start at T →
  - Reads (0,128), (1,129) … (127,255) on consecutive cycles; `pe_sel`=0.
  - Writes to (0,128) at T+11 … (127,255) at T+138; `done` at T+139.
- Address mapping:
  - `len_log`=0 → pairs (0,1), (2,3) … (254,255).
  - `len_log`=3 → k=8 gives (16,24), k=15 gives (23,31).
  - `len_log`=7 (saturation check) → identical to `len_log`=7 reads.
- Data path with PE3 golden vectors: RAM preloaded with vector u/v pairs at the layer addresses, `mode`=1 → RAM after `done` holds expected upper/lower at `addr_a`/`addr_b`; `pe_sel`=1 throughout.
- Protocol edges:
  - `start` pulsed at T+50 and during DONE → ignored.
  - `rst`=0 at k=50 → `wr_en` drops asynchronously, no `done`.
  - Restart afterwards → reads again begin at (0,len).
- Perf: with `PE_LAYER_PERF_EN`, `cyc_cnt`=138 after `done`; without it, `cyc_cnt`=0 throughout.
